// File: rtl/path_launch_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : path_launch_capture_pkg
//  Purpose  : Shared types and default constants for the delay-path
//             launch/capture controller.
//  Contents : state_t           - controller state encoding
//             c_CNT_W_DEF       - default cycle-counter width
//             c_SYNC_STAGES_DEF - default synchroniser depth
//             c_TIMEOUT_DEF     - default trial timeout in cycles
//             c_TRIAL_W         - width of the trial counter / trials input
//  Revision : 1.0 - initial release
// ============================================================================
package path_launch_capture_pkg;

    localparam int c_CNT_W_DEF       = 16;
    localparam int c_SYNC_STAGES_DEF = 2;
    localparam int c_TIMEOUT_DEF     = 1000;
    localparam int c_TRIAL_W         = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        REC    = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage : path_launch_capture_pkg
`default_nettype wire

// File: rtl/path_launch_capture_sync.sv
`default_nettype none
// ============================================================================
//  Module   : path_sync
//  Purpose  : Multi-flop synchroniser bringing the asynchronous delay-path
//             output into the clk domain. Nothing else samples the raw input.
//  Ports    : clk     - sampling clock
//             rst_n   - asynchronous active-low reset (chain clears to 0)
//             asyncIn - raw asynchronous input
//             syncOut - synchronised output, SYNC_STAGES cycles of latency
//  Revision : 1.0 - initial release
// ============================================================================
module path_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic asyncIn,
    output logic syncOut
);

    // Attributes keep the chain intact and let placement pack the flops
    // together for maximum metastability resolution time.
    (* ASYNC_REG = "TRUE", keep = "true" *)
    logic [SYNC_STAGES-1:0] r_syncChain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_syncChain <= '0;
        end else begin
            r_syncChain <= {r_syncChain[SYNC_STAGES-2:0], asyncIn};
        end
    end

    assign syncOut = r_syncChain[SYNC_STAGES-1];

endmodule : path_sync
`default_nettype wire

// File: rtl/path_launch_capture.sv
`default_nettype none
// ============================================================================
//  Module   : path_launch_capture
//  Purpose  : Launch/capture controller for one inverter-chain delay path.
//             Launches a registered edge into the path, synchronises the
//             path output back, counts cycles until the edge arrives and
//             presents the result over a valid/ready handshake.
//  Ports    : clk, rst_n   - clock, asynchronous active-low reset
//             start        - request a measurement (sampled in IDLE only)
//             trials       - trials per measurement (0 treated as 1)
//             busy         - high whenever not IDLE
//             pathInput    - launch signal to the delay path
//             pathResult   - asynchronous delay-path output
//             resultValid  - result available (held until accepted)
//             resultReady  - consumer accepts the result
//             delayCycles  - cycle count of the last trial
//             timedOut     - some trial of this measurement hit TIMEOUT
//             delaySum     - sum of all trial counts
//  Config   : PATH_ACCUM_EN - when defined, multiple trials and the delaySum
//             accumulator are built; otherwise exactly one trial runs and
//             delaySum reads 0.
//  Revision : 1.0 - initial release
// ============================================================================
module path_launch_capture
    import path_launch_capture_pkg::*;
#(
    parameter int CNT_W       = c_CNT_W_DEF,
    parameter int SYNC_STAGES = c_SYNC_STAGES_DEF,
    parameter int TIMEOUT     = c_TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [c_TRIAL_W-1:0]     trials,
    output logic                     busy,
    output logic                     pathInput,
    input  logic                     pathResult,
    output logic                     resultValid,
    input  logic                     resultReady,
    output logic [CNT_W-1:0]         delayCycles,
    output logic                     timedOut,
    output logic [CNT_W+c_TRIAL_W-1:0] delaySum
);

    localparam int               c_SETTLE_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] c_TIMEOUT  = CNT_W'(TIMEOUT);

    state_t                r_state;
    state_t                w_nextState;
    logic [c_SETTLE_W-1:0] r_settleCnt;
    logic                  r_baseline;
    logic                  r_pathInput;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      r_delayCycles;
    logic                  r_timedOut;

    logic                  w_syncOut;
    logic                  w_settleDone;
    logic                  w_mismatch;
    logic                  w_timeoutHit;
    logic                  w_trialDone;
    logic                  w_lastTrial;
    logic                  w_startAccept;
    logic [CNT_W-1:0]      w_trialCount;

    path_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pathSync (
        .clk     (clk),
        .rst_n   (rst_n),
        .asyncIn (pathResult),
        .syncOut (w_syncOut)
    );

    // SETTLE spans SYNC_STAGES+1 cycles so the synchroniser fully reflects
    // the path state left over from the previous trial before baselining.
    assign w_settleDone  = (r_settleCnt == c_SETTLE_W'(SYNC_STAGES));
    // Comparing against the captured baseline instead of an expected level
    // makes the measurement independent of path inversion parity.
    assign w_mismatch    = (w_syncOut != r_baseline);
    assign w_timeoutHit  = (r_count == c_TIMEOUT);
    assign w_trialDone   = (r_state == WAIT) && (w_mismatch || w_timeoutHit);
    assign w_trialCount  = w_mismatch ? r_count : c_TIMEOUT;
    assign w_startAccept = (r_state == IDLE) && start;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (start)        w_nextState = SETTLE;
            SETTLE:  if (w_settleDone) w_nextState = LAUNCH;
            LAUNCH:                    w_nextState = WAIT;
            WAIT:    if (w_mismatch || w_timeoutHit) w_nextState = REC;
            REC:     w_nextState = w_lastTrial ? DONE : SETTLE;
            DONE:    if (resultReady)  w_nextState = IDLE;
            default:                   w_nextState = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register and trial datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_settleCnt   <= '0;
            r_baseline    <= 1'b0;
            r_pathInput   <= 1'b0;
            r_count       <= '0;
            r_delayCycles <= '0;
            r_timedOut    <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_settleCnt <= (r_state == SETTLE) ? r_settleCnt + 1'b1 : '0;

            if (r_state == SETTLE && w_settleDone) begin
                r_baseline <= w_syncOut;
            end

            // Never re-zeroed: successive trials launch alternating edges.
            if (r_state == LAUNCH) begin
                r_pathInput <= ~r_pathInput;
                r_count     <= '0;
            end

            // Count holds at TIMEOUT because it only advances while below it.
            if (r_state == WAIT && !w_mismatch && !w_timeoutHit) begin
                r_count <= r_count + 1'b1;
            end

            if (w_trialDone) begin
                r_delayCycles <= w_trialCount;
            end

            if (w_startAccept) begin
                r_timedOut <= 1'b0;
            end else if (w_trialDone && !w_mismatch) begin
                r_timedOut <= 1'b1;
            end
        end
    end

`ifdef PATH_ACCUM_EN
    logic [c_TRIAL_W-1:0]       r_trialsLeft;
    logic [CNT_W+c_TRIAL_W-1:0] r_delaySum;

    assign w_lastTrial = (r_trialsLeft == c_TRIAL_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trialsLeft <= '0;
            r_delaySum   <= '0;
        end else begin
            if (w_startAccept) begin
                r_trialsLeft <= (trials == '0) ? c_TRIAL_W'(1) : trials;
            end else if (r_state == REC && !w_lastTrial) begin
                r_trialsLeft <= r_trialsLeft - 1'b1;
            end

            // 255 trials of at most 2^CNT_W-1 fit in CNT_W+8 bits.
            if (w_startAccept) begin
                r_delaySum <= '0;
            end else if (w_trialDone) begin
                r_delaySum <= r_delaySum + {{c_TRIAL_W{1'b0}}, w_trialCount};
            end
        end
    end

    assign delaySum = r_delaySum;
`else
    // Single-trial build: trials is deliberately not consumed.
    logic w_unusedTrials;
    assign w_unusedTrials = ^trials;
    assign w_lastTrial    = 1'b1;
    assign delaySum       = '0;
`endif

    assign busy        = (r_state != IDLE);
    assign resultValid = (r_state == DONE);
    assign pathInput   = r_pathInput;
    assign delayCycles = r_delayCycles;
    assign timedOut    = r_timedOut;

endmodule : path_launch_capture
`default_nettype wire

// File: tb/tb_path_launch_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_path_launch_capture
//  Purpose  : Directed self-checking bench for path_launch_capture. A small
//             path model feeds pathResult: loopback, 5-cycle delay, or
//             stuck at 0. Expectations follow PATH_ACCUM_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_path_launch_capture;

    localparam int CNT_W = 16;
    localparam int SYNC  = 2;
    localparam int TMO   = 50;
`ifdef PATH_ACCUM_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    localparam int MODE_LOOP  = 0;
    localparam int MODE_DLY5  = 1;
    localparam int MODE_STUCK = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       trials = 8'd0;
    logic             busy;
    logic             pathInput;
    logic             pathResult;
    logic             resultValid;
    logic             resultReady = 1'b0;
    logic [CNT_W-1:0] delayCycles;
    logic             timedOut;
    logic [CNT_W+7:0] delaySum;

    int         testCnt = 0;
    int         failCnt = 0;
    int         mode = MODE_LOOP;
    logic [4:0] dly = 5'd0;
    int         togCnt = 0;
    logic       prevPi = 1'b0;
    int         measBase = 0;
    logic       piBefore;

    path_launch_capture #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .trials      (trials),
        .busy        (busy),
        .pathInput   (pathInput),
        .pathResult  (pathResult),
        .resultValid (resultValid),
        .resultReady (resultReady),
        .delayCycles (delayCycles),
        .timedOut    (timedOut),
        .delaySum    (delaySum)
    );

    always #5 clk = ~clk;

    // Path model
    always @(posedge clk) dly <= {dly[3:0], pathInput};

    always_comb begin
        pathResult = 1'b0;
        case (mode)
            MODE_LOOP: pathResult = pathInput;
            MODE_DLY5: pathResult = dly[4];
            default:   pathResult = 1'b0;
        endcase
    end

    // Edge counter on the launch signal
    always @(negedge clk) begin
        if (pathInput !== prevPi) togCnt++;
        prevPi = pathInput;
    end

    task automatic checkValue(input string tag, input logic [31:0] act,
                              input logic [31:0] exp);
        testCnt++;
        if (act !== exp) begin
            failCnt++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where
    // resultValid is seen (or after the cycle budget).
    task automatic runMeas(input int m, input logic [7:0] ntr, input string tag);
        int  n;
        bit  got;
        mode     = m;
        trials   = ntr;
        measBase = togCnt;
        piBefore = pathInput;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkValue({tag, "_busy"}, {31'd0, busy}, 32'd1);
        got = 1'b0;
        n   = 0;
        while (!got && n < 3000) begin
            @(negedge clk);
            got = resultValid;
            n++;
        end
        checkValue({tag, "_valid"}, {31'd0, got}, 32'd1);
    endtask

    task automatic accept(input string tag);
        resultReady = 1'b1;
        @(negedge clk);
        resultReady = 1'b0;
        checkValue({tag, "_busyDrop"}, {31'd0, busy}, 32'd0);
        checkValue({tag, "_validDrop"}, {31'd0, resultValid}, 32'd0);
    endtask

    initial begin
        int n;
        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        checkValue("rst_busy",   {31'd0, busy},        32'd0);
        checkValue("rst_pi",     {31'd0, pathInput},   32'd0);
        checkValue("rst_valid",  {31'd0, resultValid}, 32'd0);
        checkValue("rst_delay",  32'(delayCycles),     32'd0);
        checkValue("rst_tmo",    {31'd0, timedOut},    32'd0);
        checkValue("rst_sum",    32'(delaySum),        32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- 5-cycle path, 4 trials ----------------
        runMeas(MODE_DLY5, 8'd4, "dly5");
        checkValue("dly5_delay", 32'(delayCycles), 32'd7);
        checkValue("dly5_sum",   32'(delaySum), ACC ? 32'd28 : 32'd0);
        checkValue("dly5_tog",   32'(togCnt - measBase), ACC ? 32'd4 : 32'd1);
        checkValue("dly5_pi",    {31'd0, pathInput}, ACC ? 32'd0 : 32'd1);
        checkValue("dly5_tmo",   {31'd0, timedOut}, 32'd0);
        accept("dly5");

        // ---------------- zero-delay loopback ----------------
        runMeas(MODE_LOOP, 8'd1, "loop");
        checkValue("loop_delay", 32'(delayCycles), 32'd2);
        checkValue("loop_tmo",   {31'd0, timedOut}, 32'd0);
        checkValue("loop_sum",   32'(delaySum), ACC ? 32'd2 : 32'd0);
        checkValue("loop_tog",   32'(togCnt - measBase), 32'd1);
        checkValue("loop_pi",    {31'd0, pathInput}, {31'd0, ~piBefore});
        accept("loop");

        // ---------------- stuck path -> timeout ----------------
        runMeas(MODE_STUCK, 8'd1, "stuck");
        checkValue("stuck_delay", 32'(delayCycles), 32'd50);
        checkValue("stuck_tmo",   {31'd0, timedOut}, 32'd1);
        checkValue("stuck_sum",   32'(delaySum), ACC ? 32'd50 : 32'd0);
        accept("stuck");

        // ---------------- loopback clears timedOut; hold in DONE ----------------
        runMeas(MODE_LOOP, 8'd1, "hold");
        checkValue("hold_tmo", {31'd0, timedOut}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            @(negedge clk);
            checkValue("hold_valid", {31'd0, resultValid}, 32'd1);
            checkValue("hold_delay", 32'(delayCycles), 32'd2);
        end
        start = 1'b0;
        checkValue("hold_busy", {31'd0, busy}, 32'd1);
        accept("hold");

        // ---------------- back-to-back start right after busy falls ----------------
        runMeas(MODE_LOOP, 8'd0, "trial0");
        checkValue("trial0_delay", 32'(delayCycles), 32'd2);
        checkValue("trial0_tog",   32'(togCnt - measBase), 32'd1);
        checkValue("trial0_sum",   32'(delaySum), ACC ? 32'd2 : 32'd0);
        accept("trial0");

        // ---------------- reset in WAIT (trial 2 when multi-trial) ----------------
        mode     = MODE_DLY5;
        trials   = 8'd3;
        measBase = togCnt;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while ((togCnt - measBase) < (ACC ? 2 : 1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkValue("rstw_reached", {31'd0, (n < 500)}, 32'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkValue("rstw_busy",  {31'd0, busy},        32'd0);
        checkValue("rstw_pi",    {31'd0, pathInput},   32'd0);
        checkValue("rstw_valid", {31'd0, resultValid}, 32'd0);
        checkValue("rstw_delay", 32'(delayCycles),     32'd0);
        checkValue("rstw_sum",   32'(delaySum),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkValue("rstw_noValid", {31'd0, resultValid}, 32'd0);
        runMeas(MODE_LOOP, 8'd1, "post");
        checkValue("post_delay", 32'(delayCycles), 32'd2);
        checkValue("post_pi",    {31'd0, pathInput}, 32'd1);
        accept("post");

        // ---------------- trials=9 loopback ----------------
        runMeas(MODE_LOOP, 8'd9, "t9");
        checkValue("t9_tog",   32'(togCnt - measBase), ACC ? 32'd9 : 32'd1);
        checkValue("t9_delay", 32'(delayCycles), 32'd2);
        checkValue("t9_sum",   32'(delaySum), ACC ? 32'd18 : 32'd0);
        accept("t9");

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", testCnt);
        $fatal(1, "watchdog");
    end

endmodule : tb_path_launch_capture
`default_nettype wire
